// File: rtl/rev_serial_uncompute_pkg.sv
// Shared definitions for the reversible serial blocks: FSM states,
// default operand width and a Peres gate helper.
package rev_serial_uncompute_pkg;

   localparam int unsigned W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Peres gate outputs: p = a, q = a ^ b, r = (a & b) ^ c
   typedef struct packed {
      logic p;
      logic q;
      logic r;
   } peres_t;

   function automatic peres_t peres(input logic a, input logic b, input logic c);
      peres_t g;
      g.p = a;
      g.q = a ^ b;
      g.r = (a & b) ^ c;
      return g;
   endfunction

endpackage

// File: rtl/rev_serial_uncompute_full_sub.sv
// Reversible full subtractor built from two Peres gates.
// d = x ^ y ^ bin, bout = (~x & y) | (~(x ^ y) & bin).
module rev_full_sub
   import rev_serial_uncompute_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   peres_t g1;
   peres_t g2;
   logic   unused_garbage;

   // g1.q = ~(x ^ y), g1.r = ~x & y. Those two terms never overlap, so
   // the XOR in g2.r acts as the OR the borrow equation needs.
   assign g1 = peres(y, ~x, 1'b0);
   assign g2 = peres(g1.q, bin, g1.r);

   // g2.q is ~(x ^ y ^ bin); invert to get the difference bit
   assign d    = ~g2.q;
   assign bout = g2.r;

   // garbage lines of the reversible gates carry no information we need
   assign unused_garbage = g1.p ^ g2.p;

endmodule

// File: rtl/rev_serial_uncompute.sv
// Bit-serial uncompute stage: recovers a = {cout,sum} - b - cin, LSB first,
// one bit per clock, and flags results no W-bit a could have produced.
module rev_serial_uncompute
   import rev_serial_uncompute_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] sum_in,
   input  logic         cout_in,
   input  logic [W-1:0] b_in,
   input  logic         cin_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] a_out,
   output logic         err
);

   localparam int unsigned   CW   = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic [W-1:0]  sum_sr;
   logic [W-1:0]  b_sr;
   logic [W-1:0]  a_sr;
   logic [W-1:0]  a_next;
   logic          borrow;
   logic          cout_r;
   logic          d;
   logic          bout;
   logic          last;

   rev_full_sub u_sub (
      .x    (sum_sr[0]),
      .y    (b_sr[0]),
      .bin  (borrow),
      .d    (d),
      .bout (bout)
   );

   assign last     = (cnt == LAST);
   assign in_ready = (state == IDLE) && !rst;

   // next a_sr value: difference bit enters from the MSB side (works for W=1)
   always_comb begin
      a_next        = a_sr >> 1;
      a_next[W-1]   = d;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last)      state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // datapath: operand capture, serial subtract, result load and handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         sum_sr    <= '0;
         b_sr      <= '0;
         a_sr      <= '0;
         borrow    <= 1'b0;
         cout_r    <= 1'b0;
         a_out     <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sum_sr <= sum_in;
                  b_sr   <= b_in;
                  cout_r <= cout_in;
                  borrow <= cin_in;
                  cnt    <= '0;
               end
            end
            RUN: begin
               sum_sr <= sum_sr >> 1;
               b_sr   <= b_sr >> 1;
               a_sr   <= a_next;
               borrow <= bout;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  a_out     <= a_next;
                  err       <= cout_r ^ bout;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rev_serial_uncompute.sv
// Self-checking bench for rev_serial_uncompute (W=4): directed cases,
// exhaustive adder round trip, random operands, backpressure and async reset.
module tb_rev_serial_uncompute;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] sum_in;
   logic         cout_in;
   logic [W-1:0] b_in;
   logic         cin_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] a_out;
   logic         err;

   int checks   = 0;
   int failures = 0;

   rev_serial_uncompute #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_in    (sum_in),
      .cout_in   (cout_in),
      .b_in      (b_in),
      .cin_in    (cin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_out     (a_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference: plain integer subtraction of the (W+1)-bit adder result
   task automatic ref_model(input logic [W-1:0] s, input logic co, input logic [W-1:0] bb,
                            input logic ci, output logic [W-1:0] ea, output logic ee);
      int total;
      int diff;
      total = int'(co) * (1 << W) + int'(s);
      diff  = total - int'(bb) - int'(ci);
      ea    = W'(diff & ((1 << W) - 1));
      ee    = (diff < 0) || (diff >= (1 << W));
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] s, input logic co,
                        input logic [W-1:0] bb, input logic ci,
                        input logic [W-1:0] ea, input logic ee);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check({tag, "/ready"}, in_ready, 1);
      sum_in = s; cout_in = co; b_in = bb; cin_in = ci; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // scramble inputs to prove they were captured
      sum_in = W'($urandom); b_in = W'($urandom);
      cout_in = 1'($urandom); cin_in = 1'($urandom);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check({tag, "/latency"}, n, W);
      check({tag, "/a_out"}, a_out, ea);
      check({tag, "/err"}, err, ee);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "/drain"}, out_valid, 0);
   endtask

   initial begin
      logic [W-1:0] ea;
      logic         ee;
      logic [W-1:0] rs;
      logic [W-1:0] rb;
      logic         rco;
      logic         rci;
      int           t;
      int           n;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      sum_in = '0; cout_in = 1'b0; b_in = '0; cin_in = 1'b0;

      // reset state
      #2;
      check("rst/out_valid", out_valid, 0);
      check("rst/a_out", a_out, 0);
      check("rst/err", err, 0);
      check("rst/in_ready", in_ready, 0);
      #10 rst = 1'b0;
      #1 check("rst/in_ready_release", in_ready, 1);
      @(posedge clk); #1;

      // directed cases
      do_op("dir1", 4'b0110, 1'b0, 4'b0011, 1'b0, 4'b0011, 1'b0);
      do_op("dir2", 4'b1110, 1'b1, 4'b1111, 1'b1, 4'b1110, 1'b0);
      do_op("neg",  4'b0000, 1'b0, 4'b0001, 1'b0, 4'b1111, 1'b1);
      do_op("ovf",  4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1111, 1'b1);

      // exhaustive round trip through an ideal W-bit adder
      for (int a = 0; a < (1 << W); a++)
         for (int b = 0; b < (1 << W); b++)
            for (int c = 0; c < 2; c++) begin
               t = a + b + c;
               do_op("rt", W'(t), 1'(t >> W), W'(b), 1'(c), W'(a), 1'b0);
            end

      // random operands, including inconsistent ones
      for (int i = 0; i < 40; i++) begin
         rs = W'($urandom); rb = W'($urandom);
         rco = 1'($urandom); rci = 1'($urandom);
         ref_model(rs, rco, rb, rci, ea, ee);
         do_op("rand", rs, rco, rb, rci, ea, ee);
      end

      // backpressure: 10 - 3 - 1 = 6
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      sum_in = 4'b1010; cout_in = 1'b0; b_in = 4'b0011; cin_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("bp/latency", n, W);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         sum_in = W'($urandom); b_in = W'($urandom);
         @(posedge clk); #1;
         check("bp/out_valid", out_valid, 1);
         check("bp/a_out", a_out, 6);
         check("bp/err", err, 0);
         check("bp/in_ready", in_ready, 0);
      end
      // in_valid together with out_ready in DONE is not accepted
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      check("bp/release_valid", out_valid, 0);
      check("bp/release_ready", in_ready, 1);
      @(posedge clk); #1;
      check("bp/not_accepted", in_ready, 1);

      // leave a nonzero result and err=1 before the reset test
      do_op("pre_rst", 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1111, 1'b1);

      // asynchronous reset after two RUN edges
      sum_in = 4'b0110; cout_in = 1'b0; b_in = 4'b0011; cin_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      check("arst/out_valid", out_valid, 0);
      check("arst/a_out", a_out, 0);
      check("arst/err", err, 0);
      check("arst/in_ready", in_ready, 0);
      #2 rst = 1'b0;
      #1 check("arst/in_ready_release", in_ready, 1);
      @(posedge clk); #1;
      check("arst/idle", in_ready, 1);
      check("arst/no_stale_valid", out_valid, 0);
      do_op("post_rst", 4'b1001, 1'b0, 4'b0010, 1'b1, 4'b0110, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
